// File: rtl/uart_rx_core_pkg.sv
// Shared UART receive definitions: RX state encodings, FIFO status masks and bit helpers.
// The `RX_STATE_* and `Fifo_* macros stand in for the codebase's uart_defines.v.
`ifndef UART_DEFINES_V
`define UART_DEFINES_V
`define RX_STATE_IDLE   3'd0
`define RX_STATE_START  3'd1
`define RX_STATE_DATA   3'd2
`define RX_STATE_PARITY 3'd3
`define RX_STATE_STOP   3'd4
`define RX_STATE_WRITE  3'd5
`define Fifo_Empty      4'b0001
`define Fifo_AEmpty     4'b0010
`define Fifo_Full       4'b0100
`endif

package uart_rx_core_pkg;

    typedef struct packed {
        logic frame;
        logic parity;
        logic overrun;
    } rx_flags_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// RX FIFO write port plus receive status flags between the UART receiver and its FIFO/status logic.
interface uart_rx_core_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] fwdata;
    logic                  fwrite;
    logic [3:0]            fwstatus;
    logic                  parity_err;
    logic                  frame_err;
    logic                  overrun_err;

    modport master (
        output fwdata, fwrite, parity_err, frame_err, overrun_err,
        input  fwstatus
    );

    modport slave (
        input  fwdata, fwrite, parity_err, frame_err, overrun_err,
        output fwstatus
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input plus one delay flop for edge detection.
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic rx_s,
    output logic rx_d
);
    logic meta_r;
    logic sync_r;
    logic dly_r;

    // Synchroniser chain; resets to the line's idle level so no false edge follows reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
            dly_r  <= RESET_VAL;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
            dly_r  <= sync_r;
        end
    end

    assign rx_s = sync_r;
    assign rx_d = dly_r;
endmodule

// File: rtl/uart_rx_core.sv
// UART receive core: start/data(LSB first)/even-parity/stop frames into RX FIFO writes.
// Build option UART_RX_MAJORITY_VOTE_EN: each bit is the 2-of-3 majority around mid-bit.
module uart_rx_core
    import uart_rx_core_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 3
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           enable_uart,
    input  logic           RX,
    uart_rx_core_if.master fifo_if
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int MID   = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(MID + 1);
`else
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(MID);
`endif

    localparam logic [2:0] ST_IDLE   = `RX_STATE_IDLE;
    localparam logic [2:0] ST_START  = `RX_STATE_START;
    localparam logic [2:0] ST_DATA   = `RX_STATE_DATA;
    localparam logic [2:0] ST_PARITY = `RX_STATE_PARITY;
    localparam logic [2:0] ST_STOP   = `RX_STATE_STOP;
    localparam logic [2:0] ST_WRITE  = `RX_STATE_WRITE;

    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction

    logic rx_s;
    logic rx_d;

    uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (RX),
        .rx_s     (rx_s),
        .rx_d     (rx_d)
    );

    logic [2:0]            state_r,  state_s;
    logic [CNT_W-1:0]      cnt_r,    cnt_s;
    logic [IDX_W-1:0]      idx_r,    idx_s;
    logic [DATA_WIDTH-1:0] shift_r,  shift_s;
    logic [DATA_WIDTH-1:0] fwdata_r, fwdata_s;
    logic                  par_r,    par_s;
    logic                  stop_r,   stop_s;
    logic                  pend_r,   pend_s;
    logic                  fwrite_r, fwrite_s;
    rx_flags_t             flags_r,  flags_s;

    logic                  edge_s;
    logic                  wrap_s;
    logic [CNT_W-1:0]      cnt_inc_s;
    logic                  sample_en_s;
    logic                  sample_bit_s;

    // Bit cells are aligned to rx_d: cnt==k sees the k-th clock of the current bit on rx_d.
    assign edge_s      = rx_d & ~rx_s;
    assign wrap_s      = (cnt_r == CNT_LAST);
    assign cnt_inc_s   = wrap_s ? {CNT_W{1'b0}} : (cnt_r + CNT_W'(1));
    assign sample_en_s = (cnt_r == CNT_SAMPLE);

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic hist1_r;
    logic hist2_r;

    // Two-deep rx_d history so the decision clock sees the samples at MID-1, MID and MID+1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist1_r <= 1'b1;
            hist2_r <= 1'b1;
        end else begin
            hist1_r <= rx_d;
            hist2_r <= hist1_r;
        end
    end

    assign sample_bit_s = maj3(hist2_r, hist1_r, rx_d);
`else
    assign sample_bit_s = rx_d;
`endif

    // Frame FSM next-state, datapath and single-cycle WRITE decision.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        idx_s    = idx_r;
        shift_s  = shift_r;
        fwdata_s = fwdata_r;
        par_s    = par_r;
        stop_s   = stop_r;
        pend_s   = pend_r;
        fwrite_s = 1'b0;
        flags_s  = '0;
        if (!enable_uart) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (edge_s) begin
                        cnt_s   = {CNT_W{1'b0}};
                        state_s = ST_START;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_START: begin
                    cnt_s = cnt_inc_s;
                    if (sample_en_s && sample_bit_s) begin
                        state_s = ST_IDLE;
                    end else if (wrap_s) begin
                        idx_s   = {IDX_W{1'b0}};
                        state_s = ST_DATA;
                    end else begin
                        state_s = ST_START;
                    end
                end
                ST_DATA: begin
                    cnt_s = cnt_inc_s;
                    if (sample_en_s) begin
                        shift_s = {sample_bit_s, shift_r[DATA_WIDTH-1:1]};
                    end else begin
                        shift_s = shift_r;
                    end
                    if (wrap_s && (idx_r == IDX_LAST)) begin
                        state_s = ST_PARITY;
                    end else if (wrap_s) begin
                        idx_s = idx_r + IDX_W'(1);
                    end else begin
                        state_s = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    cnt_s = cnt_inc_s;
                    if (sample_en_s) begin
                        par_s = sample_bit_s;
                    end else begin
                        par_s = par_r;
                    end
                    if (wrap_s) begin
                        state_s = ST_STOP;
                    end else begin
                        state_s = ST_PARITY;
                    end
                end
                ST_STOP: begin
                    cnt_s = cnt_inc_s;
                    if (sample_en_s) begin
                        stop_s  = sample_bit_s;
                        // A start edge can already be on the line at this clock; keep it for WRITE.
                        pend_s  = edge_s;
                        state_s = ST_WRITE;
                    end else begin
                        state_s = ST_STOP;
                    end
                end
                ST_WRITE: begin
                    if (!stop_r) begin
                        flags_s.frame = 1'b1;
                    end else if (par_r != even_parity(shift_r)) begin
                        flags_s.parity = 1'b1;
                    end else if ((fifo_if.fwstatus & `Fifo_Full) != 4'b0000) begin
                        flags_s.overrun = 1'b1;
                    end else begin
                        fwrite_s = 1'b1;
                        fwdata_s = shift_r;
                    end
                    pend_s = 1'b0;
                    if (pend_r) begin
                        cnt_s   = CNT_W'(1);
                        state_s = ST_START;
                    end else if (edge_s) begin
                        cnt_s   = {CNT_W{1'b0}};
                        state_s = ST_START;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            idx_r    <= {IDX_W{1'b0}};
            shift_r  <= {DATA_WIDTH{1'b0}};
            fwdata_r <= {DATA_WIDTH{1'b0}};
            par_r    <= 1'b0;
            stop_r   <= 1'b0;
            pend_r   <= 1'b0;
            fwrite_r <= 1'b0;
            flags_r  <= '0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            idx_r    <= idx_s;
            shift_r  <= shift_s;
            fwdata_r <= fwdata_s;
            par_r    <= par_s;
            stop_r   <= stop_s;
            pend_r   <= pend_s;
            fwrite_r <= fwrite_s;
            flags_r  <= flags_s;
        end
    end

    assign fifo_if.fwdata      = fwdata_r;
    assign fifo_if.fwrite      = fwrite_r;
    assign fifo_if.parity_err  = flags_r.parity;
    assign fifo_if.frame_err   = flags_r.frame;
    assign fifo_if.overrun_err = flags_r.overrun;
endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: directed frames push expected events, a monitor checks them.
module tb_uart_rx_core;
    localparam int CPB = 3;
    localparam logic [3:0] FULL     = 4'b0100;
    localparam logic [3:0] EV_WRITE = 4'b0001;
    localparam logic [3:0] EV_PAR   = 4'b0010;
    localparam logic [3:0] EV_FRAME = 4'b0100;
    localparam logic [3:0] EV_OVR   = 4'b1000;

    typedef struct packed {
        logic [3:0] code;
        logic [7:0] data;
    } ev_t;

    logic clk;
    logic reset_n;
    logic enable_uart;
    logic RX;

    int checks   = 0;
    int failures = 0;
    ev_t sb[$];
    ev_t exp_e;
    logic [3:0] ev;

    uart_rx_core_if #(.DATA_WIDTH(8)) fifo_if ();

    uart_rx_core #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable_uart (enable_uart),
        .RX          (RX),
        .fifo_if     (fifo_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_bits(input int n);
        RX = 1'b1;
        wait_clks(n * CPB);
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic par_flip, input logic stop);
        return {stop, (^d) ^ par_flip, d, 1'b0};
    endfunction

    // Drives the first nclk clocks of a frame; clock index glitch_clk is inverted.
    task automatic send_clks(input logic [10:0] f, input int nclk, input int glitch_clk);
        for (int c = 0; c < nclk; c++) begin
            RX = f[c / CPB] ^ (c == glitch_clk);
            wait_clks(1);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic par_flip, input logic stop);
        send_clks(make_frame(d, par_flip, stop), 11 * CPB, -1);
    endtask

    task automatic push(input logic [3:0] code, input logic [7:0] data);
        ev_t e;
        e.code = code;
        e.data = data;
        sb.push_back(e);
    endtask

    // Monitor: every clock with any strobe high must match the oldest expected event.
    always @(negedge clk) begin
        if (reset_n) begin
            ev = {fifo_if.overrun_err, fifo_if.frame_err, fifo_if.parity_err, fifo_if.fwrite};
            if (ev != 4'b0000) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event actual=%b required=none", ev);
                end else begin
                    exp_e = sb.pop_front();
                    if (ev !== exp_e.code) begin
                        failures++;
                        $display("FAIL event_kind actual=%b required=%b", ev, exp_e.code);
                    end else if (exp_e.code == EV_WRITE) begin
                        checks++;
                        if (fifo_if.fwdata !== exp_e.data) begin
                            failures++;
                            $display("FAIL fwdata actual=%0h required=%0h", fifo_if.fwdata, exp_e.data);
                        end
                    end
                end
            end
        end
    end

    initial begin
        RX = 1'b1;
        enable_uart = 1'b1;
        reset_n = 1'b0;
        fifo_if.fwstatus = 4'b0000;
        wait_clks(3);
        chk("reset_fwdata", 32'(fifo_if.fwdata), 32'h0);
        chk("reset_strobes", 32'({fifo_if.fwrite, fifo_if.parity_err, fifo_if.frame_err, fifo_if.overrun_err}), 32'h0);
        reset_n = 1'b1;
        idle_bits(2);

        // Single-clock low glitch on idle line: no activity expected.
        RX = 1'b0;
        wait_clks(1);
        idle_bits(12);

        push(EV_WRITE, 8'hA5);
        send(8'hA5, 1'b0, 1'b1);
        idle_bits(3);

        push(EV_PAR, 8'h00);
        send(8'h3C, 1'b1, 1'b1);
        idle_bits(3);
        chk("fwdata_hold_parity", 32'(fifo_if.fwdata), 32'hA5);

        // Framing error, then a 20-bit break that must not raise anything further.
        push(EV_FRAME, 8'h00);
        send(8'h55, 1'b0, 1'b0);
        RX = 1'b0;
        wait_clks(20 * CPB);
        idle_bits(4);

        fifo_if.fwstatus = FULL;
        push(EV_OVR, 8'h00);
        send(8'h7E, 1'b0, 1'b1);
        idle_bits(3);
        chk("fwdata_hold_overrun", 32'(fifo_if.fwdata), 32'hA5);
        fifo_if.fwstatus = 4'b0000;
        push(EV_WRITE, 8'h81);
        send(8'h81, 1'b0, 1'b1);
        idle_bits(3);

        // Back-to-back frames with no idle gap.
        push(EV_WRITE, 8'h01);
        push(EV_WRITE, 8'hFE);
        send(8'h01, 1'b0, 1'b1);
        send(8'hFE, 1'b0, 1'b1);
        idle_bits(3);

`ifdef UART_RX_MAJORITY_VOTE_EN
        // One-clock glitch in the middle of data bit 2 is outvoted.
        push(EV_WRITE, 8'hC3);
        send_clks(make_frame(8'hC3, 1'b0, 1'b1), 11 * CPB, 3 * CPB + 1);
        idle_bits(3);
`endif

        // Reset during data bit 4: outputs clear at once, partial word is lost.
        send_clks(make_frame(8'hF0, 1'b0, 1'b1), 5 * CPB + 1, -1);
        reset_n = 1'b0;
        #1;
        chk("midreset_fwdata", 32'(fifo_if.fwdata), 32'h0);
        chk("midreset_fwrite", 32'(fifo_if.fwrite), 32'h0);
        RX = 1'b1;
        wait_clks(2);
        reset_n = 1'b1;
        idle_bits(2);
        push(EV_WRITE, 8'h33);
        send(8'h33, 1'b0, 1'b1);
        idle_bits(4);

        chk("events_pending", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
